// File: rtl/mult_radix4_param.sv
// mult_radix4_param: sequential radix-4 shift-and-add multiplier.
// Signed operands are reduced to magnitudes at load time and the product
// sign is restored at the end. Iteration stops as soon as the remaining
// multiplier digits are all zero, so short multipliers finish early.
// WIDTH must be even and at least 4.
module mult_radix4_param #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mult_begin,
  input  logic               mult_signed,
  input  logic [WIDTH-1:0]   mult_op1,
  input  logic [WIDTH-1:0]   mult_op2,
  output logic [2*WIDTH-1:0] product,
  output logic               mult_end,
  output logic               mult_busy
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic             neg;

  logic             op1_neg;
  logic             op2_neg;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [PW-1:0]    partial;
  logic             mplier_zero;

  // Operand magnitudes; the most-negative value negates to itself, which
  // read as unsigned is exactly 2^(WIDTH-1).
  always_comb begin
    op1_neg = mult_signed & mult_op1[WIDTH-1];
    op2_neg = mult_signed & mult_op2[WIDTH-1];
    mag1    = op1_neg ? (~mult_op1 + {{(WIDTH-1){1'b0}}, 1'b1}) : mult_op1;
    mag2    = op2_neg ? (~mult_op2 + {{(WIDTH-1){1'b0}}, 1'b1}) : mult_op2;
  end

  // Partial product selected by the lowest radix-4 digit of the multiplier.
  always_comb begin
    partial = '0;
    case (mplier[1:0])
      2'b00:   partial = '0;
      2'b01:   partial = mcand;
      2'b10:   partial = mcand << 1;
      2'b11:   partial = mcand + (mcand << 1);
      default: partial = '0;
    endcase
  end

  assign mplier_zero = (mplier == '0);

  // State register with asynchronous abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, iterate until multiplier exhausted.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mult_begin) state_next = BUSY;
      BUSY:    if (mplier_zero) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load magnitudes, accumulate digit by digit, and register the
  // signed result on the way into DONE so it is valid while mult_end is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mult_begin) begin
            mcand  <= {{WIDTH{1'b0}}, mag1};
            mplier <= mag2;
            acc    <= '0;
            neg    <= mult_signed & (mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1]);
          end
        end
        BUSY: begin
          if (!mplier_zero) begin
            acc    <= acc + partial;
            mcand  <= mcand << 2;
            mplier <= mplier >> 2;
          end else begin
            product <= neg ? (~acc + {{(PW-1){1'b0}}, 1'b1}) : acc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mult_end  = (state == DONE);
  assign mult_busy = (state != IDLE);

endmodule

// File: tb/tb_mult_radix4_param.sv
// tb_mult_radix4_param: directed vector table for WIDTH=32, hand sequences
// for busy-time input changes and mid-operation reset, and a back-to-back
// run of a WIDTH=8 instance against a native multiply.
module tb_mult_radix4_param;

  logic        clk;
  logic        reset;
  logic        mult_begin;
  logic        mult_signed;
  logic [31:0] mult_op1;
  logic [31:0] mult_op2;
  logic [63:0] product;
  logic        mult_end;
  logic        mult_busy;

  logic        begin8;
  logic        signed8;
  logic [7:0]  op1_8;
  logic [7:0]  op2_8;
  logic [15:0] product8;
  logic        end8;
  logic        busy8;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_p;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  mult_radix4_param #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .mult_begin(mult_begin),
    .mult_signed(mult_signed),
    .mult_op1(mult_op1),
    .mult_op2(mult_op2),
    .product(product),
    .mult_end(mult_end),
    .mult_busy(mult_busy)
  );

  mult_radix4_param #(.WIDTH(8)) dut8 (
    .clk(clk),
    .reset(reset),
    .mult_begin(begin8),
    .mult_signed(signed8),
    .mult_op1(op1_8),
    .mult_op2(op2_8),
    .product(product8),
    .mult_end(end8),
    .mult_busy(busy8)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case anything hangs.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Starts one WIDTH=32 operation and returns the negedge index (counted
  // from the start edge) at which mult_end is first seen, plus the product.
  task automatic apply_stimulus(input logic sgn, input logic [31:0] a,
                                input logic [31:0] b, output int lat,
                                output logic [63:0] p);
    bit seen;
    @(negedge clk);
    mult_signed = sgn;
    mult_op1    = a;
    mult_op2    = b;
    mult_begin  = 1'b1;
    @(posedge clk);
    lat  = 0;
    p    = '0;
    seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      mult_begin = 1'b0;
      if (mult_end) begin
        seen = 1;
        lat  = i;
        p    = product;
      end
    end
  endtask

  function automatic logic [15:0] ref8(input logic s, input logic [7:0] a,
                                       input logic [7:0] b);
    int x;
    if (s) x = int'($signed(a)) * int'($signed(b));
    else   x = int'({24'b0, a}) * int'({24'b0, b});
    return x[15:0];
  endfunction

  initial begin
    int          lat;
    logic [63:0] p;
    int          ends;
    logic [63:0] seen_p;
    logic [7:0]  ca[4];
    logic [7:0]  cb[4];
    logic        cs[4];
    bit          got;

    vecs[0]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 18};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'h00000003, 64'hFFFFFFFFFFFFFFEB, 3};
    vecs[2]  = '{1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 18};
    vecs[3]  = '{1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000, 18};
    vecs[4]  = '{1'b0, 32'h12345678, 32'h00000000, 64'h0000000000000000, 2};
    vecs[5]  = '{1'b0, 32'h00000005, 32'h00000006, 64'h000000000000001E, 4};
    vecs[6]  = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000, 3};
    vecs[7]  = '{1'b1, 32'h00000064, 32'hFFFFFF9C, 64'hFFFFFFFFFFFFD8F0, 6};
    vecs[8]  = '{1'b0, 32'h00010000, 32'h00010000, 64'h0000000100000000, 11};
    vecs[9]  = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000, 18};
    vecs[10] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, 3};
    vecs[11] = '{1'b0, 32'hDEADBEEF, 32'h00000001, 64'h00000000DEADBEEF, 3};

    reset       = 1'b1;
    mult_begin  = 1'b0;
    mult_signed = 1'b0;
    mult_op1    = '0;
    mult_op2    = '0;
    begin8      = 1'b0;
    signed8     = 1'b0;
    op1_8       = '0;
    op2_8       = '0;
    #1;
    check_output("reset_product", product, 64'h0);
    check_output("reset_end", {63'b0, mult_end}, 64'h0);
    check_output("reset_busy", {63'b0, mult_busy}, 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed vector table");
    for (int v = 0; v < 12; v++) begin
      apply_stimulus(vecs[v].sgn, vecs[v].a, vecs[v].b, lat, p);
      check_output($sformatf("vec%0d_product", v), p, vecs[v].exp_p);
      check_output($sformatf("vec%0d_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
      @(negedge clk);
      check_output($sformatf("vec%0d_end_pulse", v), {63'b0, mult_end}, 64'h0);
      check_output($sformatf("vec%0d_hold", v), product, vecs[v].exp_p);
    end

    $display("[TB] input activity while busy");
    @(negedge clk);
    mult_signed = 1'b0;
    mult_op1    = 32'hFFFFFFFF;
    mult_op2    = 32'hFFFFFFFF;
    mult_begin  = 1'b1;
    @(posedge clk);
    ends   = 0;
    seen_p = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 5) check_output("busy_mid_op", {63'b0, mult_busy}, 64'h1);
      if (mult_end) begin
        ends++;
        seen_p = product;
      end
      if (i < 12) begin
        mult_begin  = ~mult_begin;
        mult_signed = ~mult_signed;
        mult_op1    = $urandom;
        mult_op2    = $urandom;
      end else begin
        mult_begin = 1'b0;
      end
    end
    check_output("busy_toggle_ends", 64'(ends), 64'h1);
    check_output("busy_toggle_product", seen_p, 64'hFFFFFFFE00000001);

    $display("[TB] reset during a long operation");
    @(negedge clk);
    mult_signed = 1'b0;
    mult_op1    = 32'hFFFFFFFF;
    mult_op2    = 32'hFFFFFFFF;
    mult_begin  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mult_begin = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_output("abort_product", product, 64'h0);
    check_output("abort_end", {63'b0, mult_end}, 64'h0);
    check_output("abort_busy", {63'b0, mult_busy}, 64'h0);
    repeat (2) @(negedge clk);
    mult_op1   = 32'd5;
    mult_op2   = 32'd6;
    mult_begin = 1'b1;
    reset      = 1'b0;
    @(posedge clk);
    lat = 0;
    p   = '0;
    ends = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      mult_begin = 1'b0;
      if (mult_end) begin
        ends++;
        if (lat == 0) begin
          lat = i;
          p   = product;
        end
      end
    end
    check_output("after_reset_product", p, 64'd30);
    check_output("after_reset_latency", 64'(lat), 64'd4);
    check_output("after_reset_ends", 64'(ends), 64'h1);

    $display("[TB] WIDTH=8 back-to-back run");
    ca[0] = 8'h80; cb[0] = 8'h80; cs[0] = 1'b1;
    ca[1] = 8'hFF; cb[1] = 8'hFF; cs[1] = 1'b0;
    ca[2] = 8'hFF; cb[2] = 8'h80; cs[2] = 1'b1;
    ca[3] = 8'h00; cb[3] = 8'h00; cs[3] = 1'b0;
    @(negedge clk);
    signed8 = cs[0];
    op1_8   = ca[0];
    op2_8   = cb[0];
    begin8  = 1'b1;
    for (int k = 0; k < 60; k++) begin
      got = 0;
      for (int i = 0; i < 30 && !got; i++) begin
        @(negedge clk);
        if (end8) got = 1;
      end
      if (!got) begin
        check_output($sformatf("w8_op%0d_timeout", k), 64'h0, 64'h1);
        break;
      end
      check_output($sformatf("w8_op%0d_product", k), {48'b0, product8},
                   {48'b0, ref8(signed8, op1_8, op2_8)});
      if (k + 1 < 4) begin
        signed8 = cs[k+1];
        op1_8   = ca[k+1];
        op2_8   = cb[k+1];
      end else begin
        signed8 = 1'(k % 2);
        op1_8   = 8'($urandom);
        op2_8   = 8'($urandom);
      end
    end
    begin8 = 1'b0;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
